// File: rtl/alineador_store_pkg.sv
// alineador_store_pkg: shared size codes, FSM encoding and helpers for the store aligner
package alineador_store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_e;

  // codes 10 and 11 both mean a full word
  function automatic logic es_word(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/alineador_store_if.sv
// alineador_store_if: request handshake plus word-memory port of the store aligner
interface alineador_store_if #(
  parameter int TAM_DATO = 32,
  parameter int TAM_DIR  = 32,
  parameter int TAM_MASK = 2
);
  logic                i_valid;
  logic [TAM_MASK-1:0] i_mascara;
  logic [TAM_DIR-1:0]  i_dir;
  logic [TAM_DATO-1:0] i_dato;
  logic                o_ready;
  logic                o_done;
  logic                o_error;
  logic [TAM_DIR-3:0]  o_mem_dir;
  logic                o_mem_rd;
  logic                o_mem_wr;
  logic [TAM_DATO-1:0] o_mem_wdata;
  logic [TAM_DATO-1:0] i_mem_rdata;

  modport master (
    output i_valid, i_mascara, i_dir, i_dato, i_mem_rdata,
    input  o_ready, o_done, o_error, o_mem_dir, o_mem_rd, o_mem_wr, o_mem_wdata
  );

  modport slave (
    input  i_valid, i_mascara, i_dir, i_dato, i_mem_rdata,
    output o_ready, o_done, o_error, o_mem_dir, o_mem_rd, o_mem_wr, o_mem_wdata
  );
endinterface

// File: rtl/alineador_store_fusionador_bytes.sv
// fusionador_bytes: overlays a byte or halfword onto a little-endian word
module fusionador_bytes
  import alineador_store_pkg::*;
#(
  parameter int TAM_DATO = 32
) (
  input  logic [TAM_DATO-1:0] i_viejo,
  input  logic [TAM_DATO-1:0] i_dato,
  input  logic [1:0]          i_tam,
  input  logic [1:0]          i_off,
  output logic [TAM_DATO-1:0] o_nuevo
);

  // replace only the addressed lane(s); halfword lanes are chosen by offset bit 1 alone
  always_comb begin
    o_nuevo = i_viejo;
    if (i_tam == SZ_BYTE) o_nuevo[{i_off, 3'b000} +: 8] = i_dato[7:0];
    else if (i_tam == SZ_HALF) o_nuevo[{i_off[1], 4'b0000} +: 16] = i_dato[15:0];
    else o_nuevo = i_dato;
  end

endmodule

// File: rtl/alineador_store.sv
// alineador_store: sub-word store via read-modify-write; STORE_MISALIGN_CHECK_EN enables misalignment rejection
module alineador_store
  import alineador_store_pkg::*;
#(
  parameter int TAM_DATO = 32,
  parameter int TAM_DIR  = 32,
  parameter int TAM_MASK = 2
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  alineador_store_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          mask_q, mask_d;
  logic [1:0]          off_q, off_d;
  logic [TAM_DATO-1:0] dato_q, dato_d;
  logic [TAM_DIR-3:0]  memdir_q, memdir_d;
  logic [TAM_DATO-1:0] wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [TAM_MASK-1:0] masc;
  logic [1:0]          m;
  logic [TAM_DATO-1:0] fusion;

  assign masc = bus.i_mascara;
  assign m    = masc[1:0];

`ifdef STORE_MISALIGN_CHECK_EN
  logic desal;
  assign desal = (m == SZ_HALF && bus.i_dir[0]) || (es_word(m) && bus.i_dir[1:0] != 2'b00);
`endif

  fusionador_bytes #(.TAM_DATO(TAM_DATO)) u_fusion (
    .i_viejo(bus.i_mem_rdata),
    .i_dato (dato_q),
    .i_tam  (mask_q),
    .i_off  (off_q),
    .o_nuevo(fusion)
  );

  // next-state and registered strobes; strobes default low so each fires once per request
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    off_d    = off_q;
    dato_d   = dato_q;
    memdir_d = memdir_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        mask_d   = m;
        off_d    = bus.i_dir[1:0];
        dato_d   = bus.i_dato;
        memdir_d = bus.i_dir[TAM_DIR-1:2];
`ifdef STORE_MISALIGN_CHECK_EN
        if (desal) begin
          state_d = ERR;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else
`endif
        if (es_word(m)) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          done_d  = 1'b1;
          wdata_d = bus.i_dato;
        end else begin
          state_d = READ;
          rd_d    = 1'b1;
        end
      end
      READ:  state_d = MERGE;
      MERGE: begin
        state_d = WRITE;
        wr_d    = 1'b1;
        done_d  = 1'b1;
        wdata_d = fusion;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; async reset drops any request in flight
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      off_q    <= '0;
      dato_q   <= '0;
      memdir_q <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      off_q    <= off_d;
      dato_q   <= dato_d;
      memdir_q <= memdir_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.o_ready     = state_q == IDLE;
  assign bus.o_done      = done_q;
  assign bus.o_error     = error_q;
  assign bus.o_mem_dir   = memdir_q;
  assign bus.o_mem_rd    = rd_q;
  assign bus.o_mem_wr    = wr_q;
  assign bus.o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_alineador_store.sv
// tb_alineador_store: scoreboard bench for the store aligner
module tb_alineador_store;

  typedef struct {
    int          k;
    int          cyc;
    logic [29:0] dir;
    logic [31:0] d;
  } ev_t;

  localparam int K_RD = 0, K_WR = 1, K_ERR = 2;
  localparam int T_WORD = 0, T_RMW = 1, T_ERR = 2, T_RDONLY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rd_word = 32'h0;
  ev_t  q[$];
  ev_t  e;
  int   k;

  alineador_store_if #(.TAM_DATO(32), .TAM_DIR(32), .TAM_MASK(2)) bus ();

  alineador_store #(.TAM_DATO(32), .TAM_DIR(32), .TAM_MASK(2)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.i_mem_rdata <= bus.o_mem_rd ? rd_word : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.o_mem_rd || bus.o_mem_wr || bus.o_done || bus.o_error)) begin
      k = bus.o_mem_wr ? K_WR : bus.o_mem_rd ? K_RD : K_ERR;
      if (bus.o_mem_rd && bus.o_mem_wr) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (q.size() == 0) chk("unexpected_event_kind", k, 32'hFFFFFFFF);
      else begin
        e = q.pop_front();
        chk("event_kind", k, e.k);
        chk("event_cycle", cyc, e.cyc);
        chk("done", {31'd0, bus.o_done}, {31'd0, e.k != K_RD});
        chk("error", {31'd0, bus.o_error}, {31'd0, e.k == K_ERR});
        if (e.k != K_ERR) chk("mem_dir", {2'b00, bus.o_mem_dir}, {2'b00, e.dir});
        if (e.k == K_WR) chk("wdata", bus.o_mem_wdata, e.d);
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [31:0] dir, input logic [31:0] dato,
                       input logic [31:0] rdw, input int t, input logic [31:0] wexp);
    int n = 0;
    int a;
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_mascara = m;
    bus.i_dir     = dir;
    bus.i_dato    = dato;
    rd_word       = rdw;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) chk("accept_timeout", 32'd0, 32'd1);
    a = cyc;
    if (t == T_WORD) q.push_back('{K_WR, a + 1, dir[31:2], wexp});
    if (t == T_RMW || t == T_RDONLY) q.push_back('{K_RD, a + 1, dir[31:2], 32'h0});
    if (t == T_RMW) q.push_back('{K_WR, a + 3, dir[31:2], wexp});
    if (t == T_ERR) q.push_back('{K_ERR, a + 1, 30'h0, 32'h0});
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.o_error}, 32'd0);
    chk({tag, "_mem_rd"}, {31'd0, bus.o_mem_rd}, 32'd0);
    chk({tag, "_mem_wr"}, {31'd0, bus.o_mem_wr}, 32'd0);
    chk({tag, "_mem_dir"}, {2'b00, bus.o_mem_dir}, 32'd0);
    chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'd0);
  endtask

  initial begin
    int n;
    bus.i_valid   = 1'b0;
    bus.i_mascara = 2'b00;
    bus.i_dir     = 32'h0;
    bus.i_dato    = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.o_ready}, 32'd1);

    issue(2'b10, 32'h10, 32'hDEADBEEF, 32'h0, T_WORD, 32'hDEADBEEF);
    drop_valid();
    issue(2'b00, 32'h13, 32'h000000AB, 32'h11223344, T_RMW, 32'hAB223344);
    drop_valid();
    issue(2'b01, 32'h12, 32'hFFFFCAFE, 32'h11223344, T_RMW, 32'hCAFE3344);
    drop_valid();
    issue(2'b00, 32'h10, 32'h123456CD, 32'hA5A5A5A5, T_RMW, 32'hA5A5A5CD);
    drop_valid();
    issue(2'b00, 32'h21, 32'h00000077, 32'h00000000, T_RMW, 32'h00007700);
    drop_valid();
`ifdef STORE_MISALIGN_CHECK_EN
    issue(2'b01, 32'h11, 32'h0000BEEF, 32'h11223344, T_ERR, 32'h0);
    drop_valid();
    issue(2'b11, 32'h13, 32'h01020304, 32'h0, T_ERR, 32'h0);
    drop_valid();
`else
    issue(2'b01, 32'h11, 32'h0000BEEF, 32'h11223344, T_RMW, 32'h1122BEEF);
    drop_valid();
    issue(2'b11, 32'h13, 32'h01020304, 32'h0, T_WORD, 32'h01020304);
    drop_valid();
`endif

    issue(2'b00, 32'h13, 32'h000000AB, 32'h11223344, T_RDONLY, 32'h0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_merge_reset");
    chk("ready_in_reset", {31'd0, bus.o_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("after_abort");
    issue(2'b10, 32'h40, 32'hCAFEF00D, 32'h0, T_WORD, 32'hCAFEF00D);
    drop_valid();

    issue(2'b10, 32'h20, 32'h11111111, 32'h11223344, T_WORD, 32'h11111111);
    issue(2'b00, 32'h22, 32'h0000005A, 32'h11223344, T_RMW, 32'h115A3344);
    issue(2'b10, 32'h24, 32'h22222222, 32'h11223344, T_WORD, 32'h22222222);
    drop_valid();

    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
